// File: rtl/serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_pkg
// Shared definitions for the bit-serial adder controller.
//   state_e : FSM state encoding (IDLE / RUN / DONE). The fourth code of the
//             2-bit register is unused and recovers to S_IDLE.
// ---------------------------------------------------------------------------
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle of the bit-serial adder.
//   start, a, b, cin      : request side, driven by the master
//   ready, busy, done     : controller status, driven by the slave
//   sum, cout             : registered result, driven by the slave
// WIDTH must match the WIDTH of the serial_add_ctrl instance it connects to.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl_fa_cell.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_fa_cell
// Purely combinational one-bit full adder, the single arithmetic cell that the
// serial controller reuses once per bit.
//   a_i, b_i, cin_i : operand bits and carry-in
//   s_o             : sum bit
//   cout_o          : carry-out bit (majority of the three inputs)
// ---------------------------------------------------------------------------
module serial_add_ctrl_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule : serial_add_ctrl_fa_cell

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: computes {cout, sum} = a + b + cin by feeding one bit per
// cycle, LSB first, through a single full-adder cell, holding the carry in a
// flop between bits.
//   clk     : system clock, all state on the rising edge
//   rst_n   : asynchronous active-low reset
//   bus_if  : slave side of serial_add_ctrl_if
//             start/a/b/cin sampled only while ready=1
//             ready=IDLE, busy=RUN, done=one-cycle pulse in DONE
//             sum/cout registered, held until the next result load
// Timing: accept on edge E0, bit steps on E1..E_WIDTH, result and done valid
// in the cycle after E_WIDTH; one operation per WIDTH+2 cycles.
// WIDTH legal range is 2..32.
// ---------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus_if
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] sum_sh_d;

  // The one shared arithmetic cell, always looking at the current LSBs.
  serial_add_ctrl_fa_cell u_fa_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .s_o    (s_bit),
    .cout_o (c_bit)
  );

  // New sum bit enters at the MSB so that after WIDTH steps bit 0 of the
  // operands has travelled down to bit 0 of the result.
  assign sum_sh_d = {s_bit, sum_sh_q[WIDTH-1:1]};

  // NOTE: every register here is a small flop (no memory arrays), so all of
  // them are cleared by the async reset; sequential state uses non-blocking
  // assignments only, so every right-hand side sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            a_sh_q   <= bus_if.a;
            b_sh_q   <= bus_if.b;
            carry_q  <= bus_if.cin;
            cnt_q    <= '0;
            sum_sh_q <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= c_bit;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Visible result changes only here, so the previous sum stays
          // readable for the whole of a new RUN.
          if (cnt_q == LAST) begin
            sum_q   <= sum_sh_d;
            cout_q  <= c_bit;
            state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_if.ready = (state_q == S_IDLE);
  assign bus_if.busy  = (state_q == S_RUN);
  assign bus_if.done  = (state_q == S_DONE);
  assign bus_if.sum   = sum_q;
  assign bus_if.cout  = cout_q;

endmodule : serial_add_ctrl

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: shares a single full-adder cell across WIDTH cycles to compute sum = a + b + cin.
- Accepts an operand pair through a start/ready handshake and sequences LSB-first through the fa cell, holding carry in a flop.
- Presents a registered result with a one-cycle done pulse.
- Sits beside the combinational adder library as the area-minimal sequential alternative to ripple/parallel adders.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived localparam, not overridden.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- ready  output  1  high in IDLE only (state==IDLE, combinational from the state register).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE state.
- sum  output  WIDTH  registered result; held until the next result load.
- cout  output  1  registered carry-out; held with sum.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, a_sh=b_sh=sum_sh=0, carry=0, cnt=0, sum=0, cout=0. Outputs during and after reset: ready=1, busy=0, done=0.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE when cnt==WIDTH-1 at the clock edge.
  - DONE -> IDLE unconditionally after one cycle.
- Accept (IDLE & start):
  - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0.
  - Operand changes after this edge have no effect.
- RUN, each edge:
  - fa cell computes s_bit, c_bit from (a_sh[0], b_sh[0], carry).
  - a_sh, b_sh shift right one place (zero fill).
  - sum_sh<={s_bit, sum_sh[WIDTH-1:1]}; carry<=c_bit; cnt<=cnt+1.
- Last RUN edge (cnt==WIDTH-1):
  - sum<={s_bit, sum_sh[WIDTH-1:1]}, cout<=c_bit, state<=DONE.
  - sum and cout change only on this edge (and on reset).
- Latency: start accepted at edge E0. The WIDTH bit-steps occupy edges E1..E_WIDTH. done=1 and the new sum/cout are valid in the cycle after E_WIDTH. Throughput is one operation per WIDTH+2 cycles.
- Arithmetic: {cout,sum} == a+b+cin, modulo 2^(WIDTH+1). No overflow flag.
- Boundary conditions:
  - start in RUN or DONE: ignored, never queued; ready=0 in both states.
  - start held high continuously: a new operation is accepted on each return to IDLE.
  - cnt does not wrap inside RUN; it is reset on accept.
  - rst_n low mid-RUN: operation aborted, all outputs return to reset values immediately. The first edge after reset release is an IDLE cycle.
  - Previous sum/cout remain visible during a new RUN until that RUN's final edge.

Decomposition:
- Shared header serial_add_defs:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Encoding 2'd3 is illegal and recovers to S_IDLE.
- One sub-module, fa_cell: purely combinational full adder.
  - s = a^b^cin.
  - cout = a&b | a&cin | b&cin.
  - Instantiated once, fed from the LSBs of the shift registers and the carry flop.
- Remaining logic in serial_add_ctrl: FSM, counter, shift registers, output registers.

Test Plan:
1. rst_n=0 for 3 cycles, then released -> sum=0, cout=0, ready=1, busy=0, done=0. Repeat with rst_n pulsed low at cnt=4 of a RUN -> outputs immediately at reset values, no done pulse.
2. WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start one cycle -> busy high 8 cycles, done pulse exactly 8 edges after the accept edge, sum=8'h96, cout=0.
3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
4. Start with a=8'h10, b=8'h20, cin=0; during RUN drive start=1, a=8'h01, b=8'h01 -> ignored, result sum=8'h30, cout=0, exactly one done pulse.
5. start held high through two operations (8'h01+8'h02, then 8'h7F+8'h01) -> second accepted in the IDLE cycle after DONE. Results 8'h03 then 8'h80. Spacing between done pulses is 10 cycles.
6. WIDTH=3, exhaustive 128 combinations of a, b, cin with random start gaps 0..3 cycles -> every {cout,sum} equals a+b+cin. done count equals accept count.
